// File: rtl/cp0_exc_commit_if.sv
// Writeback-to-CP0 commit bundle: exception record, MTC0/MFC0 access,
// interrupt lines and the flush/redirect and interrupt-pending responses.
interface cp0_exc_commit_if;
    logic        wb_valid;
    logic [31:0] pc;
    logic [31:0] badvaddr;
    logic [4:0]  excCode;
    logic        is_exc;
    logic        is_in_ds;
    logic        is_eret;
    logic        cp0_wen;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [5:0]  hw_int;
    logic        exc_flush;
    logic [31:0] exc_target_pc;
    logic        int_pending;

    modport master (
        output wb_valid, pc, badvaddr, excCode, is_exc, is_in_ds, is_eret,
               cp0_wen, cp0_waddr, cp0_wdata, cp0_raddr, hw_int,
        input  cp0_rdata, exc_flush, exc_target_pc, int_pending
    );

    modport slave (
        input  wb_valid, pc, badvaddr, excCode, is_exc, is_in_ds, is_eret,
               cp0_wen, cp0_waddr, cp0_wdata, cp0_raddr, hw_int,
        output cp0_rdata, exc_flush, exc_target_pc, int_pending
    );
endinterface

// File: rtl/cp0_exc_commit.sv
// Commit-side CP0: applies exception/ERET/MTC0 records at writeback, runs the
// Count/Compare timer, and issues a registered one-cycle flush/redirect.
module cp0_exc_commit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input logic            clk,
    input logic            reset,
    cp0_exc_commit_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] badvaddr_q, count_q, compare_q, epc_q;
    logic [7:0]  im_q;
    logic        exl_q, ie_q;
    logic        bd_q, ti_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exccode_q;
    logic        tick_q;

    logic        exc_c, eret_c, mtc0_c;
    logic [7:0]  ip;
    logic [31:0] status_w, cause_w;

    // Exception outranks ERET and suppresses MTC0 in the same record.
    assign exc_c  = bus.wb_valid & bus.is_exc;
    assign eret_c = bus.wb_valid & bus.is_eret & ~bus.is_exc;
    assign mtc0_c = bus.wb_valid & bus.cp0_wen & ~bus.is_exc;

    assign ip       = {ip_hw_q, ip_sw_q};
    assign status_w = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_w  = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
            ip_hw_q   <= '0;
        end else begin
            tick_q <= ~tick_q;
            if (mtc0_c && bus.cp0_waddr == REG_COUNT)
                count_q <= bus.cp0_wdata;
            else if (tick_q)
                count_q <= count_q + 32'd1;
            // A Compare write clears TI even when Count==Compare that cycle.
            if (mtc0_c && bus.cp0_waddr == REG_COMPARE) begin
                compare_q <= bus.cp0_wdata;
                ti_q      <= 1'b0;
            end else if (count_q == compare_q) begin
                ti_q <= 1'b1;
            end
            ip_hw_q <= {bus.hw_int[5] | ti_q, bus.hw_int[4:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
        end else begin
            if (mtc0_c) begin
                case (bus.cp0_waddr)
                    REG_STATUS: begin
                        im_q  <= bus.cp0_wdata[15:8];
                        exl_q <= bus.cp0_wdata[1];
                        ie_q  <= bus.cp0_wdata[0];
                    end
                    REG_CAUSE: ip_sw_q <= bus.cp0_wdata[9:8];
                    REG_EPC:   epc_q   <= bus.cp0_wdata;
                    default: ;
                endcase
            end
            if (eret_c)
                exl_q <= 1'b0;
            if (exc_c) begin
                if (!exl_q) begin
                    epc_q <= bus.pc;
                    bd_q  <= bus.is_in_ds;
                end
                exccode_q <= bus.excCode;
                exl_q     <= 1'b1;
                if (bus.excCode == 5'h04 || bus.excCode == 5'h05)
                    badvaddr_q <= bus.badvaddr;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.exc_flush     <= 1'b0;
            bus.exc_target_pc <= '0;
        end else begin
            bus.exc_flush <= exc_c | eret_c;
            if (exc_c)
                bus.exc_target_pc <= EXC_VECTOR;
            else if (eret_c)
                bus.exc_target_pc <= epc_q;
        end
    end

    assign bus.int_pending = ie_q & ~exl_q & (|(ip & im_q));

    always_comb begin
        bus.cp0_rdata = '0;
        case (bus.cp0_raddr)
            REG_BADVADDR: bus.cp0_rdata = badvaddr_q;
            REG_COUNT:    bus.cp0_rdata = count_q;
            REG_COMPARE:  bus.cp0_rdata = compare_q;
            REG_STATUS:   bus.cp0_rdata = status_w;
            REG_CAUSE:    bus.cp0_rdata = cause_w;
            REG_EPC:      bus.cp0_rdata = epc_q;
            default:      bus.cp0_rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc_commit.sv
// Bench for cp0_exc_commit: directed scenarios plus random commits checked
// against a word-level model of the CP0 registers.
module tb_cp0_exc_commit;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic clk;
    logic reset;
    cp0_exc_commit_if bus ();

    cp0_exc_commit #(.EXC_VECTOR(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference state kept as whole architectural words.
    logic [31:0] m_status, m_cause, m_epc, m_bva, m_cnt, m_cmp, m_tgt;
    logic        m_tick, m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_cause  = '0;
        m_epc    = '0;
        m_bva    = '0;
        m_cnt    = '0;
        m_cmp    = '0;
        m_tgt    = '0;
        m_tick   = 1'b0;
        m_flush  = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_cnt;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        return m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
    endfunction

    task automatic model_step();
        logic exc, eret, mtc;
        logic [31:0] n_s, n_c, n_epc, n_bva, n_cnt, n_cmp;
        exc  = bus.wb_valid & bus.is_exc;
        eret = bus.wb_valid & bus.is_eret & ~bus.is_exc;
        mtc  = bus.wb_valid & bus.cp0_wen & ~bus.is_exc;
        n_s = m_status; n_c = m_cause; n_epc = m_epc;
        n_bva = m_bva; n_cnt = m_cnt; n_cmp = m_cmp;
        if (m_tick) n_cnt = m_cnt + 32'd1;
        if (m_cnt == m_cmp) n_c[30] = 1'b1;
        n_c[15:10] = {bus.hw_int[5] | m_cause[30], bus.hw_int[4:0]};
        if (mtc) begin
            case (bus.cp0_waddr)
                5'd9:  n_cnt = bus.cp0_wdata;
                5'd11: begin n_cmp = bus.cp0_wdata; n_c[30] = 1'b0; end
                5'd12: n_s = (bus.cp0_wdata & 32'h0000_FF03) | 32'h0040_0000;
                5'd13: n_c = (n_c & ~32'h0000_0300) | (bus.cp0_wdata & 32'h0000_0300);
                5'd14: n_epc = bus.cp0_wdata;
                default: ;
            endcase
        end
        if (eret) n_s[1] = 1'b0;
        if (exc) begin
            if (!m_status[1]) begin
                n_epc = bus.pc;
                n_c[31] = bus.is_in_ds;
            end
            n_c[6:2] = bus.excCode;
            n_s[1] = 1'b1;
            if (bus.excCode == 5'h04 || bus.excCode == 5'h05) n_bva = bus.badvaddr;
        end
        m_flush = exc | eret;
        if (m_flush) m_tgt = exc ? VEC : m_epc;
        m_tick = ~m_tick;
        m_status = n_s; m_cause = n_c; m_epc = n_epc;
        m_bva = n_bva; m_cnt = n_cnt; m_cmp = n_cmp;
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("exc_flush", bus.exc_flush, m_flush);
        if (m_flush) check("exc_target_pc", bus.exc_target_pc, m_tgt);
        check("int_pending", bus.int_pending, m_int());
        check("cp0_rdata", bus.cp0_rdata, m_read(bus.cp0_raddr));
    endtask

    task automatic idle(input logic [4:0] raddr);
        bus.wb_valid  = 1'b0;
        bus.pc        = '0;
        bus.badvaddr  = '0;
        bus.excCode   = '0;
        bus.is_exc    = 1'b0;
        bus.is_in_ds  = 1'b0;
        bus.is_eret   = 1'b0;
        bus.cp0_wen   = 1'b0;
        bus.cp0_waddr = '0;
        bus.cp0_wdata = '0;
        bus.cp0_raddr = raddr;
        bus.hw_int    = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input logic [4:0] raddr);
        idle(raddr);
        bus.wb_valid  = 1'b1;
        bus.cp0_wen   = 1'b1;
        bus.cp0_waddr = a;
        bus.cp0_wdata = d;
        cycle();
    endtask

    task automatic exc_rec(input logic [31:0] pc, input logic [4:0] code, input logic ds,
                           input logic [31:0] bva, input logic [4:0] raddr);
        idle(raddr);
        bus.wb_valid = 1'b1;
        bus.is_exc   = 1'b1;
        bus.pc       = pc;
        bus.excCode  = code;
        bus.is_in_ds = ds;
        bus.badvaddr = bva;
    endtask

    task automatic rand_inputs();
        logic [4:0] addrs [8];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3, 5'd0};
        bus.wb_valid  = ($urandom_range(0, 9) < 7);
        bus.is_exc    = ($urandom_range(0, 9) == 0);
        bus.is_eret   = ($urandom_range(0, 9) == 0);
        bus.cp0_wen   = ($urandom_range(0, 9) < 4);
        if (bus.is_eret && !bus.is_exc) bus.cp0_wen = 1'b0;
        bus.pc        = $urandom;
        bus.badvaddr  = $urandom;
        case ($urandom_range(0, 2))
            0:       bus.excCode = 5'h04;
            1:       bus.excCode = 5'h05;
            default: bus.excCode = 5'($urandom);
        endcase
        bus.is_in_ds  = 1'($urandom);
        bus.cp0_waddr = addrs[$urandom_range(0, 7)];
        bus.cp0_wdata = ($urandom_range(0, 3) == 0) ? m_cnt + 32'd3 : $urandom;
        bus.cp0_raddr = addrs[$urandom_range(0, 7)];
        bus.hw_int    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        reset = 1'b1;
        idle(5'd12);
        model_reset();
        @(negedge clk);
        check("reset_status", bus.cp0_rdata, 32'h0040_0000);
        check("reset_flush", bus.exc_flush, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle(5'd13);
        cycle();
        check("reset_ti", bus.cp0_rdata[30], 1'b1);

        // Timer: Count=0, Compare=5, IM7+IE.
        mtc0(5'd12, 32'h0000_8001, 5'd12);
        mtc0(5'd9, 32'h0, 5'd9);
        mtc0(5'd11, 32'd5, 5'd13);
        check("compare_clears_ti", bus.cp0_rdata[30], 1'b0);
        idle(5'd13);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            if (bus.cp0_rdata[30]) seen = 1'b1;
        end
        check("timer_ti_set", seen, 1'b1);
        cycle();
        check("timer_ip7", bus.cp0_rdata[15], 1'b1);
        check("timer_int_pending", bus.int_pending, 1'b1);
        mtc0(5'd11, 32'd1000, 5'd13);
        check("compare_write_clears_ti", bus.cp0_rdata[30], 1'b0);

        // Write with wb_valid low is ignored; unmapped register reads zero.
        idle(5'd14);
        bus.cp0_wen = 1'b1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
        cycle();
        check("mtc0_no_valid", bus.cp0_rdata, 32'h0);
        idle(5'd3);
        cycle();
        check("mfc0_unmapped", bus.cp0_rdata, 32'h0);

        // Delay-slot AdEL with a concurrent MTC0 that must be suppressed.
        exc_rec(32'hBFC0_0100, 5'h04, 1'b1, 32'h1, 5'd14);
        bus.cp0_wen = 1'b1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
        cycle();
        check("ds_flush", bus.exc_flush, 1'b1);
        check("ds_target", bus.exc_target_pc, VEC);
        check("ds_epc", bus.cp0_rdata, 32'hBFC0_0100);
        idle(5'd13);
        cycle();
        check("ds_bd", bus.cp0_rdata[31], 1'b1);
        check("ds_exccode", 32'(bus.cp0_rdata[6:2]), 32'd4);
        idle(5'd8);
        cycle();
        check("ds_badvaddr", bus.cp0_rdata, 32'h1);
        idle(5'd12);
        cycle();
        check("ds_exl", bus.cp0_rdata[1], 1'b1);

        // Nested exception while EXL=1.
        exc_rec(32'h8000_0000, 5'h08, 1'b0, 32'hFFFF_0000, 5'd14);
        cycle();
        check("nest_flush", bus.exc_flush, 1'b1);
        check("nest_target", bus.exc_target_pc, VEC);
        check("nest_epc", bus.cp0_rdata, 32'hBFC0_0100);
        idle(5'd13);
        cycle();
        check("nest_bd", bus.cp0_rdata[31], 1'b1);
        check("nest_exccode", 32'(bus.cp0_rdata[6:2]), 32'd8);
        idle(5'd8);
        cycle();
        check("nest_badvaddr", bus.cp0_rdata, 32'h1);

        // ERET back to a written EPC, then the same record as an exception.
        mtc0(5'd14, 32'hBFC0_0200, 5'd14);
        idle(5'd12);
        bus.wb_valid = 1'b1; bus.is_eret = 1'b1;
        cycle();
        check("eret_flush", bus.exc_flush, 1'b1);
        check("eret_target", bus.exc_target_pc, 32'hBFC0_0200);
        check("eret_exl", bus.cp0_rdata[1], 1'b0);
        bus.is_exc = 1'b1; bus.excCode = 5'h00; bus.pc = 32'h0000_1234;
        cycle();
        check("eret_exc_flush", bus.exc_flush, 1'b1);
        check("eret_exc_target", bus.exc_target_pc, VEC);
        check("eret_exc_exl", bus.cp0_rdata[1], 1'b1);
        idle(5'd12);
        cycle();
        check("flush_one_cycle", bus.exc_flush, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle();
        end

        // Reset asserted in the middle of a flush pulse.
        exc_rec(32'h0000_4000, 5'h05, 1'b0, 32'h55, 5'd12);
        cycle();
        check("pre_reset_flush", bus.exc_flush, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("async_reset_flush", bus.exc_flush, 1'b0);
        check("async_reset_target", bus.exc_target_pc, 32'h0);
        check("async_reset_status", bus.cp0_rdata, 32'h0040_0000);
        bus.cp0_raddr = 5'd14;
        #1;
        check("async_reset_epc", bus.cp0_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(5'd13);
        cycle();
        check("rerelease_ti", bus.cp0_rdata[30], 1'b1);

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
